// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package serial_arith_pkg;

  // Controller states, 2-bit encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Width of a counter that indexes bits 0..w-1; never narrower than one bit
  function automatic int CNT_W(input int w);
    if (w <= 1) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated from the current operand bits
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a_in - b_in), LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flip-flop.
// start is accepted only in IDLE; done pulses for one cycle once the result
// registers have been updated.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int            CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             bw_reg, bw_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             borrow_reg, borrow_next;
  logic             overflow_reg, overflow_next;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_shift;

  // The single arithmetic cell always works on the current LSBs
  full_subtractor_cell u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (bw_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result shift register with the new difference bit entering at the MSB;
  // after WIDTH shifts bit 0 of the result has travelled down to bit 0
  always_comb begin
    res_shift = (res_reg >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
  end

  // Next-state logic for the FSM, datapath and result registers
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    res_next      = res_reg;
    bw_next       = bw_reg;
    cnt_next      = cnt_reg;
    diff_next     = diff_reg;
    borrow_next   = borrow_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a_in;
          b_next     = b_in;
          res_next   = '0;
          bw_next    = 1'b0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        a_next   = a_reg >> 1;
        b_next   = b_reg >> 1;
        res_next = res_shift;
        bw_next  = cell_bout;
        if (cnt_reg == CNT_LAST) begin
          // On the last bit a_reg[0]/b_reg[0] are the operand MSBs and
          // cell_d is the result MSB, which is all overflow needs
          state_next    = DONE;
          diff_next     = res_shift;
          borrow_next   = cell_bout;
          overflow_next = (a_reg[0] ^ b_reg[0]) & (cell_d ^ a_reg[0]);
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      bw_reg       <= 1'b0;
      cnt_reg      <= '0;
      diff_reg     <= '0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      res_reg      <= res_next;
      bw_reg       <= bw_next;
      cnt_reg      <= cnt_next;
      diff_reg     <= diff_next;
      borrow_reg   <= borrow_next;
      overflow_reg <= overflow_next;
    end
  end

  // Status flags decode straight from the state register
  always_comb begin
    busy       = (state_reg == SHIFT);
    done       = (state_reg == DONE);
    diff       = diff_reg;
    borrow_out = borrow_reg;
    overflow   = overflow_reg;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=8 and a WIDTH=1 instance.
// Expected results are queued when an operation is launched and popped when
// the DUT pulses done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, bo8, ov8;

  logic       start1;
  logic [0:0] a1, b1, diff1;
  logic       busy1, done1, bo1, ov1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a_in       (a8),
    .b_in       (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8),
    .overflow   (ov8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a_in       (a1),
    .b_in       (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bo1),
    .overflow   (ov1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference for the 8-bit instance: plain 9-bit arithmetic
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] full;
    full = {1'b0, a} - {1'b0, b};
    e.d  = full[7:0];
    e.bo = (a < b);
    e.ov = (a[7] != b[7]) && (full[7] != a[7]);
    return e;
  endfunction

  // Reference for the 1-bit instance
  function automatic exp_t model1(input logic a, input logic b);
    exp_t       e;
    logic [1:0] full;
    full = {1'b0, a} - {1'b0, b};
    e.d  = {7'd0, full[0]};
    e.bo = full[1];
    e.ov = (a != b) && (full[0] != a);
    return e;
  endfunction

  // Launch one 8-bit operation and observe it for 30 edges after acceptance
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int repulse_at,
                      input bit armed, output int lat, output int pulses,
                      output bit busy_ok, output bit hold_ok, output exp_t obs);
    logic [7:0] prev;
    lat = -1; pulses = 0; busy_ok = 1'b1; hold_ok = 1'b1; obs = 'x;
    if (!armed) begin
      @(negedge clk);
      start8 = 1'b1;
    end
    a8 = a; b8 = b;
    prev = diff8;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int k = 1; k <= 30; k++) begin
      start8 = (k == repulse_at);
      if (k == repulse_at) begin
        a8 = 8'hAA; b8 = 8'h55;
      end
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        if (busy8) busy_ok = 1'b0;
        if (lat < 0) begin
          lat = k;
          obs = {diff8, bo8, ov8};
        end
      end else if (lat < 0) begin
        if (!busy8) busy_ok = 1'b0;
        if (diff8 !== prev) hold_ok = 1'b0;
      end
    end
    start8 = 1'b0;
    $display("op8 a=%h b=%h diff=%h borrow=%b ovf=%b latency=%0d pulses=%0d",
             a, b, obs.d, obs.bo, obs.ov, lat, pulses);
  endtask

  // Launch one 1-bit operation and observe it for 10 edges after acceptance
  task automatic run1(input logic a, input logic b, output int lat, output int pulses,
                      output exp_t obs);
    lat = -1; pulses = 0; obs = 'x;
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          obs = {7'd0, diff1, bo1, ov1};
        end
      end
    end
    $display("op1 a=%b b=%b diff=%b borrow=%b ovf=%b latency=%0d pulses=%0d",
             a, b, obs.d[0], obs.bo, obs.ov, lat, pulses);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #23;
    checks++;
    if ({busy8, done8, diff8, bo8, ov8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_w8 got %h want 000", {busy8, done8, diff8, bo8, ov8});
    end
    checks++;
    if ({busy1, done1, diff1, bo1, ov1} !== 5'd0) begin
      errors++;
      $display("FAIL reset_w1 got %h want 00", {busy1, done1, diff1, bo1, ov1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] ta[4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [7:0] tb[4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    int lat, pulses;
    bit busy_ok, hold_ok;
    exp_t obs, e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model8(ta[i], tb[i]));
      run8(ta[i], tb[i], 0, 1'b0, lat, pulses, busy_ok, hold_ok, obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic_result[%0d] got %h want %h", i, obs, e);
      end
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d want 8", i, lat);
      end
      checks++;
      if (pulses !== 1) begin
        errors++;
        $display("FAIL basic_pulses[%0d] got %0d want 1", i, pulses);
      end
      checks++;
      if (!busy_ok || !hold_ok) begin
        errors++;
        $display("FAIL basic_busy_hold[%0d] got busy_ok=%b hold_ok=%b want 1 1", i, busy_ok, hold_ok);
      end
    end
  endtask

  task automatic test_restart();
    int lat, pulses;
    bit busy_ok, hold_ok;
    exp_t obs, e;
    sb.push_back(model8(8'h10, 8'h01));
    run8(8'h10, 8'h01, 3, 1'b0, lat, pulses, busy_ok, hold_ok, obs);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL restart_result got %h want %h", obs, e);
    end
    checks++;
    if (lat !== 8 || pulses !== 1) begin
      errors++;
      $display("FAIL restart_timing got lat=%0d pulses=%0d want lat=8 pulses=1", lat, pulses);
    end
    checks++;
    if (!busy_ok || !hold_ok) begin
      errors++;
      $display("FAIL restart_busy_hold got busy_ok=%b hold_ok=%b want 1 1", busy_ok, hold_ok);
    end
  endtask

  task automatic test_reset_abort();
    int lat, pulses;
    bit busy_ok, hold_ok, saw_done;
    exp_t obs, e;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, diff8, bo8, ov8} !== 12'd0) begin
      errors++;
      $display("FAIL abort_async got %h want 000", {busy8, done8, diff8, bo8, ov8});
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1'b1;
    end
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        sb.push_back(model8(8'h00, 8'h00));
        run8(8'h00, 8'h00, 0, 1'b1, lat, pulses, busy_ok, hold_ok, obs);
      end
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done got done=1 want 0");
    end
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_next_result got %h want %h", obs, e);
    end
    checks++;
    if (lat !== 8 || pulses !== 1) begin
      errors++;
      $display("FAIL abort_next_timing got lat=%0d pulses=%0d want lat=8 pulses=1", lat, pulses);
    end
  endtask

  task automatic test_width1();
    int lat, pulses;
    exp_t obs, e;
    logic a, b;
    for (int i = 0; i < 4; i++) begin
      a = (i >= 2);
      b = (i % 2 == 1);
      sb.push_back(model1(a, b));
      run1(a, b, lat, pulses, obs);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL w1_result[%0d] got %h want %h", i, obs, e);
      end
      checks++;
      if (lat !== 1 || pulses !== 1) begin
        errors++;
        $display("FAIL w1_timing[%0d] got lat=%0d pulses=%0d want lat=1 pulses=1", i, lat, pulses);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_reset_abort();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
